shift_word_deserializer: RTL

Serial-in/parallel-out collector that reassembles WIDTH-bit words from the 1-bit stream produced by the 32-bit shift register's serial end (SL/SR style shifting). It sits at the receiving end of the serial link. The bit order is selectable per word, MSB-first (left shift) or LSB-first (right shift). Completed words go to a separate output holding register with a valid/ready handshake, so the next word can be collected while the previous one waits to be consumed.

---
 rtl/shift_word_deserializer.sv | 109 ++++++++++
 1 files changed

// File: rtl/shift_word_deserializer.sv
// rtl/shift_word_deserializer.sv - serial-in/parallel-out word collector with valid/ready output holding register
module shift_word_deserializer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SIN,
  input  logic             START,
  input  logic             DIR,
  input  logic             Q_READY,
  input  logic             CLR_OVR,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic             BUSY,
  output logic [CNT_W-1:0] BIT_CNT,
  output logic             OVR
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic             state;
  logic             busy;
  logic             dir_l;
  logic [WIDTH-1:0] sh;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             ovr;

  logic             start_ev;
  logic             shift_ev;
  logic             complete;
  logic             xfer;
  logic             q_load;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] reload;

  // A START bit always opens a new word; plain bits only count while a word is open.
  assign start_ev = EN & START;
  assign shift_ev = EN & ~START & (state == ST_SHIFT);
  assign complete = shift_ev & (bit_cnt == CNT_W'(WIDTH - 1));
  assign xfer     = q_valid & Q_READY;
  // Completed word may enter Q if Q is empty or being drained on this same edge.
  assign q_load   = complete & (~q_valid | Q_READY);

  // Next shift register value using the direction latched at the word's first bit.
  assign shifted = dir_l ? {SIN, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], SIN};
  // First bit of a word, placed as if shifted into a cleared register with the new DIR.
  assign reload  = DIR ? {SIN, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, SIN};

  // Collection FSM: shift register, bit counter, latched direction and busy flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      dir_l   <= 1'b0;
      sh      <= '0;
      bit_cnt <= '0;
    end else if (start_ev) begin
      state   <= ST_SHIFT;
      busy    <= 1'b1;
      dir_l   <= DIR;
      sh      <= reload;
      bit_cnt <= CNT_W'(1);
    end else if (complete) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      sh      <= shifted;
      bit_cnt <= '0;
    end else if (shift_ev) begin
      sh      <= shifted;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Output holding register with valid/ready handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (q_load) begin
      q       <= shifted;
      q_valid <= 1'b1;
    end else if (xfer) begin
      q_valid <= 1'b0;
    end
  end

  // Sticky overrun: a new overrun takes priority over a clear on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr <= 1'b0;
    end else if (complete & q_valid & ~Q_READY) begin
      ovr <= 1'b1;
    end else if (CLR_OVR) begin
      ovr <= 1'b0;
    end
  end

  assign Q       = q;
  assign Q_VALID = q_valid;
  assign BUSY    = busy;
  assign BIT_CNT = bit_cnt;
  assign OVR     = ovr;

endmodule
